// File: rtl/prog_loader_if.sv
// Byte-stream input and program-RAM write port of the serial program loader.
// The loader is the slave side; the source/RAM environment is the master side.
interface prog_loader_if #(
  parameter int ROM_WIDTH  = 21,
  parameter int ADDR_WIDTH = 16
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ROM_WIDTH-1:0]  wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// Serial program loader: parses a length-prefixed, XOR-checksummed byte image
// into instruction words and writes them into program RAM, holding the CPU meanwhile.
module prog_loader #(
  parameter int ROM_WIDTH  = 21,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  prog_loader_if.slave   bus,
  output logic           busy,
  output logic           done,
  output logic           error,
  output logic           cpu_hold
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR
  } state_t;

  // Bits of the first word byte at or above this position must be zero.
  localparam int HI_SHIFT = (ROM_WIDTH > 16) ? ROM_WIDTH - 16 : 0;
  localparam logic [16:0]           DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_L  = ADDR_WIDTH'(BASE_ADDR);

  state_t      state, next_state;
  logic [7:0]  csum;
  logic [7:0]  len_hi;
  logic [15:0] n_words;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  b0, b1;

  logic        accept;
  logic        start_ok;
  logic        hi_bad;
  logic [15:0] len_word;

  assign accept   = bus.in_valid && bus.in_ready;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
  assign hi_bad   = |(bus.in_data >> HI_SHIFT);
  assign len_word = {len_hi, bus.in_data};

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = LEN_HI;
      LEN_HI:          if (accept) next_state = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_word == 16'd0)               next_state = CHK;
          else if ({1'b0, len_word} > DEPTH_L) next_state = ERR;
          else                                 next_state = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          if (byte_cnt == 2'd0 && hi_bad)
            next_state = ERR;
          else if (byte_cnt == 2'd2 && (word_cnt + 16'd1) == n_words)
            next_state = CHK;
        end
      end
      CHK: if (accept) next_state = ((csum ^ bus.in_data) == 8'd0) ? DONE : ERR;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      busy         <= 1'b0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= next_state;
      bus.in_ready <= (next_state == LEN_HI || next_state == LEN_LO ||
                       next_state == DATA   || next_state == CHK);
      busy         <= (next_state == LEN_HI || next_state == LEN_LO ||
                       next_state == DATA   || next_state == CHK);
      cpu_hold     <= (next_state != IDLE && next_state != DONE);
      done         <= (next_state == DONE);
      error        <= (next_state == ERR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= BASE_L;
      bus.wr_data <= '0;
      csum        <= 8'd0;
      len_hi      <= 8'd0;
      n_words     <= 16'd0;
      word_cnt    <= 16'd0;
      byte_cnt    <= 2'd0;
      b0          <= 8'd0;
      b1          <= 8'd0;
    end else begin
      bus.wr_en <= 1'b0;
      if (bus.wr_en) bus.wr_addr <= bus.wr_addr + 1'b1;
      if (start_ok) begin
        bus.wr_addr <= BASE_L;
        csum        <= 8'd0;
        word_cnt    <= 16'd0;
        byte_cnt    <= 2'd0;
      end
      if (accept) begin
        csum <= csum ^ bus.in_data;
        case (state)
          LEN_HI: len_hi  <= bus.in_data;
          LEN_LO: n_words <= len_word;
          DATA: begin
            case (byte_cnt)
              2'd0: begin b0 <= bus.in_data; byte_cnt <= 2'd1; end
              2'd1: begin b1 <= bus.in_data; byte_cnt <= 2'd2; end
              default: begin
                byte_cnt    <= 2'd0;
                word_cnt    <= word_cnt + 16'd1;
                bus.wr_en   <= 1'b1;
                bus.wr_data <= ROM_WIDTH'({b0, b1, bus.in_data});
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: good images, gapped input,
// zero-length, oversize header, format/checksum errors and mid-load reset.
module tb_prog_loader;

  logic clk;
  logic rst;
  logic start;
  logic busy, done, error, cpu_hold;

  int err_count;
  int check_count;

  logic [7:0]  stim[$];
  logic [15:0] log_addr[$];
  logic [20:0] log_data[$];

  prog_loader_if #(.ROM_WIDTH(21), .ADDR_WIDTH(16)) bus ();

  prog_loader #(
    .ROM_WIDTH(21), .ADDR_WIDTH(16), .DEPTH(1024), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en) begin
      log_addr.push_back(bus.wr_addr);
      log_data.push_back(bus.wr_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput("in_ready_gap", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    log_addr.delete();
    log_data.delete();
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_done_clr", 32'(done), 32'd0);
    checkOutput("start_err_clr", 32'(error), 32'd0);
  endtask

  task automatic applyStimulus(input int gap);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i]);
      if (gap > 0 && i < stim.size() - 1) idle_gap(gap);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic load_good(input logic [7:0] chk);
    stim = '{8'h00, 8'h02, 8'h01, 8'hD0, 8'h01, 8'h01, 8'hA0, 8'h00, chk};
  endtask

  task automatic check_final(input string tag, input logic d, input logic e, input int nwr);
    checkOutput({tag, "_done"}, 32'(done), 32'(d));
    checkOutput({tag, "_error"}, 32'(error), 32'(e));
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'(e));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, "_nwr"}, 32'(log_addr.size()), 32'(nwr));
  endtask

  task automatic check_two_writes(input string tag);
    if (log_addr.size() == 2) begin
      checkOutput({tag, "_a0"}, 32'(log_addr[0]), 32'h0);
      checkOutput({tag, "_d0"}, 32'(log_data[0]), 32'h1D001);
      checkOutput({tag, "_a1"}, 32'(log_addr[1]), 32'h1);
      checkOutput({tag, "_d1"}, 32'(log_data[1]), 32'h1A000);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_addr"}, 32'(bus.wr_addr), 32'd0);
    checkOutput({tag, "_data"}, 32'(bus.wr_data), 32'd0);
  endtask

  task automatic run_good(input string tag, input int gap);
    do_start();
    load_good(8'h73);
    applyStimulus(gap);
    check_final(tag, 1'b1, 1'b0, 2);
    check_two_writes(tag);
  endtask

  initial begin
    err_count    = 0;
    check_count  = 0;
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_hold", 32'(cpu_hold), 32'd0);

    $display("[TB] test 1: continuous image");
    run_good("t1", 0);

    $display("[TB] test 2: gapped image");
    run_good("t2", 3);

    $display("[TB] test 3: zero-length images");
    do_start();
    stim = '{8'h00, 8'h00, 8'h00};
    applyStimulus(0);
    check_final("t3ok", 1'b1, 1'b0, 0);
    do_start();
    stim = '{8'h00, 8'h00, 8'h55};
    applyStimulus(0);
    check_final("t3bad", 1'b0, 1'b1, 0);

    $display("[TB] test 4: oversize header");
    do_start();
    stim = '{8'h04, 8'h01};
    applyStimulus(0);
    check_final("t4", 1'b0, 1'b1, 0);
    run_good("t4rec", 0);

    $display("[TB] test 5: format and checksum errors");
    do_start();
    stim = '{8'h00, 8'h01, 8'h20};
    applyStimulus(0);
    check_final("t5fmt", 1'b0, 1'b1, 0);
    do_start();
    load_good(8'h72);
    applyStimulus(0);
    check_final("t5chk", 1'b0, 1'b1, 2);
    check_two_writes("t5chk");

    $display("[TB] test 6: reset mid-load");
    do_start();
    stim = '{8'h00, 8'h02, 8'h01, 8'hD0};
    applyStimulus(0);
    checkOutput("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_rel");
    checkOutput("t6_nwr", 32'(log_addr.size()), 32'd0);
    run_good("t6rerun", 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
